// File: rtl/eeg_pea_out_arb.sv
// Round-robin collector of PE output streams onto one output-RAM write port, with pass completion tracking.
// Latency: a beat accepted in cycle t is presented on ORAM_* in cycle t+1 through one register stage.
// Backpressure: while ORAM_VLD=1 and ORAM_RDY=0 no PE is granted and ORAM_* hold their values.
module eeg_pea_out_arb #(
    parameter int  PE_ROW      = 4,
    parameter int  PE_COL      = 4,
    parameter int  DATA_OUT_DW = 8,
    parameter int  OMUX_ADD_AW = 8,
    localparam int PE_NUM      = PE_ROW * PE_COL,
    localparam int PE_IW       = $clog2(PE_NUM),
    localparam int OADD_AW     = PE_IW + OMUX_ADD_AW
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            START,
    input  logic [PE_NUM-1:0]               CFG_PE_MSK,
    output logic                            IS_IDLE,
    output logic                            DONE,
    output logic [15:0]                     WR_CNT,
    input  logic [PE_NUM-1:0]               OUT_VLD,
    input  logic [PE_NUM-1:0]               OUT_LST,
    output logic [PE_NUM-1:0]               OUT_RDY,
    input  logic [PE_NUM*DATA_OUT_DW-1:0]   OUT_DAT,
    input  logic [PE_NUM*OMUX_ADD_AW-1:0]   OUT_ADD,
    output logic                            ORAM_VLD,
    input  logic                            ORAM_RDY,
    output logic [OADD_AW-1:0]              ORAM_ADD,
    output logic [DATA_OUT_DW-1:0]          ORAM_DAT
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    state_t                  state_q, state_d;
    logic [PE_NUM-1:0]       msk_q, msk_d;
    logic [PE_NUM-1:0]       lst_seen_q, lst_seen_d;
    logic [PE_IW-1:0]        ptr_q, ptr_d;
    logic [15:0]             wr_cnt_q, wr_cnt_d;
    logic                    oram_vld_q, oram_vld_d;
    logic [OADD_AW-1:0]      oram_add_q, oram_add_d;
    logic [DATA_OUT_DW-1:0]  oram_dat_q, oram_dat_d;

    logic [PE_NUM-1:0]       req;
    logic [PE_IW-1:0]        gnt_idx;
    logic                    gnt_vld;
    logic                    ld;
    logic                    acc;

    assign req = (state_q == S_RUN) ? (OUT_VLD & msk_q & ~lst_seen_q) : '0;
    assign ld  = (state_q == S_RUN) && (!oram_vld_q || ORAM_RDY);
    assign acc = ld && gnt_vld;

    // Scan from the farthest offset down so the nearest requester at or after ptr wins.
    always_comb begin
        int idx;
        idx     = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = PE_NUM - 1; k >= 0; k--) begin
            idx = (int'(ptr_q) + k) % PE_NUM;
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx[PE_IW-1:0];
            end
        end
    end

    always_comb begin
        OUT_RDY = '0;
        if (acc) begin
            OUT_RDY[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        msk_d      = msk_q;
        lst_seen_d = lst_seen_q;
        ptr_d      = ptr_q;
        wr_cnt_d   = wr_cnt_q;
        oram_vld_d = oram_vld_q;
        oram_add_d = oram_add_q;
        oram_dat_d = oram_dat_q;
        if (state_q == S_IDLE && START) begin
            msk_d      = CFG_PE_MSK;
            lst_seen_d = '0;
            wr_cnt_d   = '0;
        end
        if (acc) begin
            oram_vld_d = 1'b1;
            oram_add_d = {gnt_idx, OUT_ADD[gnt_idx*OMUX_ADD_AW +: OMUX_ADD_AW]};
            oram_dat_d = OUT_DAT[gnt_idx*DATA_OUT_DW +: DATA_OUT_DW];
            ptr_d      = (gnt_idx == PE_IW'(PE_NUM - 1)) ? '0 : gnt_idx + PE_IW'(1);
            if (wr_cnt_q != 16'hFFFF) begin
                wr_cnt_d = wr_cnt_q + 16'd1;
            end
            if (OUT_LST[gnt_idx]) begin
                lst_seen_d[gnt_idx] = 1'b1;
            end
        end else if (ORAM_RDY) begin
            oram_vld_d = 1'b0;
        end
    end

    // Completion uses next-cycle lst_seen so the beat that closes the pass counts immediately.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (START) state_d = S_RUN;
            S_RUN:   if (&(lst_seen_d | ~msk_q)) state_d = S_DRAIN;
            S_DRAIN: if (!oram_vld_q || ORAM_RDY) state_d = S_FIN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msk_q      <= '0;
            lst_seen_q <= '0;
            ptr_q      <= '0;
            wr_cnt_q   <= '0;
            oram_vld_q <= 1'b0;
            oram_add_q <= '0;
            oram_dat_q <= '0;
        end else begin
            msk_q      <= msk_d;
            lst_seen_q <= lst_seen_d;
            ptr_q      <= ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            oram_vld_q <= oram_vld_d;
            oram_add_q <= oram_add_d;
            oram_dat_q <= oram_dat_d;
        end
    end

    assign IS_IDLE  = (state_q == S_IDLE);
    assign DONE     = (state_q == S_FIN);
    assign WR_CNT   = wr_cnt_q;
    assign ORAM_VLD = oram_vld_q;
    assign ORAM_ADD = oram_add_q;
    assign ORAM_DAT = oram_dat_q;

endmodule

// File: tb/tb_eeg_pea_out_arb.sv
// Randomized and directed stimulus for eeg_pea_out_arb, checked every cycle against a rule-level model.
module tb_eeg_pea_out_arb;
    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          START = 1'b0;
    logic [N-1:0]  CFG_PE_MSK = '0;
    logic          IS_IDLE, DONE, ORAM_VLD;
    logic [15:0]   WR_CNT;
    logic [N-1:0]  OUT_VLD = '0, OUT_LST = '0, OUT_RDY;
    logic [N*8-1:0] OUT_DAT = '0, OUT_ADD = '0;
    logic          ORAM_RDY = 1'b0;
    logic [11:0]   ORAM_ADD;
    logic [7:0]    ORAM_DAT;

    eeg_pea_out_arb dut (
        .clk(clk), .rst_n(rst_n), .START(START), .CFG_PE_MSK(CFG_PE_MSK),
        .IS_IDLE(IS_IDLE), .DONE(DONE), .WR_CNT(WR_CNT),
        .OUT_VLD(OUT_VLD), .OUT_LST(OUT_LST), .OUT_RDY(OUT_RDY),
        .OUT_DAT(OUT_DAT), .OUT_ADD(OUT_ADD),
        .ORAM_VLD(ORAM_VLD), .ORAM_RDY(ORAM_RDY), .ORAM_ADD(ORAM_ADD), .ORAM_DAT(ORAM_DAT)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_bad = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: pass phase 0=idle 1=run 2=drain 3=fin
    int           m_ph = 0, m_ptr = 0, m_cnt = 0;
    logic [N-1:0] m_msk = '0, m_seen = '0;
    logic         m_ovld = 1'b0;
    logic [11:0]  m_oadd = '0;
    logic [7:0]   m_odat = '0;

    logic [11:0] wr_add[$];
    logic [7:0]  wr_dat[$];
    int          wr_cyc[$];
    int          done_cnt = 0, done_cyc = 0, start_cyc = 0;

    always @(negedge clk) begin
        logic [N-1:0] req, exp_rdy;
        int g, best, d;
        logic old_ovld;
        cyc++;
        if (!rst_n) begin
            m_ph = 0; m_ptr = 0; m_cnt = 0; m_msk = '0; m_seen = '0;
            m_ovld = 1'b0; m_oadd = '0; m_odat = '0;
        end
        req = (m_ph == 1) ? (OUT_VLD & m_msk & ~m_seen) : '0;
        g = -1; best = N;
        for (int i = 0; i < N; i++) begin
            d = (i - m_ptr + N) % N;
            if (req[i] && d < best) begin best = d; g = i; end
        end
        exp_rdy = '0;
        if (m_ph == 1 && (!m_ovld || ORAM_RDY) && g >= 0) exp_rdy[g] = 1'b1;

        chk("is_idle", 32'(IS_IDLE), 32'(m_ph == 0));
        chk("done", 32'(DONE), 32'(m_ph == 3));
        chk("wr_cnt", 32'(WR_CNT), 32'(m_cnt));
        chk("out_rdy", 32'(OUT_RDY), 32'(exp_rdy));
        chk("oram_vld", 32'(ORAM_VLD), 32'(m_ovld));
        chk("oram_add", 32'(ORAM_ADD), 32'(m_oadd));
        chk("oram_dat", 32'(ORAM_DAT), 32'(m_odat));

        if (rst_n) begin
            if (ORAM_VLD && ORAM_RDY) begin
                wr_add.push_back(ORAM_ADD); wr_dat.push_back(ORAM_DAT); wr_cyc.push_back(cyc);
            end
            if (DONE) begin done_cnt++; done_cyc = cyc; end
            if (START && IS_IDLE) start_cyc = cyc;

            old_ovld = m_ovld;
            if (exp_rdy != '0) begin
                m_ovld = 1'b1;
                m_oadd = {4'(g), OUT_ADD[g*8 +: 8]};
                m_odat = OUT_DAT[g*8 +: 8];
                m_ptr  = (g + 1) % N;
                if (m_cnt < 65535) m_cnt++;
                if (OUT_LST[g]) m_seen[g] = 1'b1;
            end else if (ORAM_RDY) begin
                m_ovld = 1'b0;
            end
            case (m_ph)
                0: if (START) begin m_ph = 1; m_msk = CFG_PE_MSK; m_seen = '0; m_cnt = 0; end
                1: if ((m_seen | ~m_msk) == {N{1'b1}}) m_ph = 2;
                2: if (!old_ovld || ORAM_RDY) m_ph = 3;
                default: m_ph = 0;
            endcase
        end
    end

    // PE stream drivers
    logic [N-1:0] drv_msk = '0;
    int  left[N], sent[N], plan[N];
    int  vld_pct = 100, rdy_pct = 100, stall_left = 0;
    bit  junk = 0, stale = 0, rnd_dat = 0;

    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = OUT_VLD & OUT_RDY;
        @(posedge clk);
        #1;
        START = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && left[i] > 0) begin left[i]--; sent[i]++; end
            OUT_LST[i] = 1'b0;
            OUT_VLD[i] = 1'b0;
            if (drv_msk[i] && left[i] > 0) begin
                OUT_VLD[i] = ($urandom_range(0, 99) < vld_pct);
                OUT_LST[i] = (left[i] == 1);
            end else if ((stale && drv_msk[i]) || (junk && !drv_msk[i])) begin
                OUT_VLD[i] = $urandom_range(0, 1) == 1;
                OUT_LST[i] = $urandom_range(0, 1) == 1;
            end
            OUT_ADD[i*8 +: 8] = rnd_dat ? 8'($urandom) : 8'(8'h10 + sent[i]);
            OUT_DAT[i*8 +: 8] = rnd_dat ? 8'($urandom) : 8'(8'hA1 + sent[i]);
        end
        if (stall_left > 0) begin
            ORAM_RDY = 1'b0;
            stall_left--;
        end else begin
            ORAM_RDY = ($urandom_range(0, 99) < rdy_pct);
        end
    endtask

    task automatic clear_drv();
        drv_msk = '0;
        for (int i = 0; i < N; i++) begin left[i] = 0; sent[i] = 0; end
        wr_add.delete(); wr_dat.delete(); wr_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_drv();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic start_pass(input logic [N-1:0] msk);
        clear_drv();
        drv_msk = msk;
        for (int i = 0; i < N; i++) left[i] = msk[i] ? plan[i] : 0;
        CFG_PE_MSK = msk;
        START = 1'b1;
        step();
    endtask

    task automatic wait_done();
        int dc0;
        int n;
        dc0 = done_cnt;
        n = 0;
        while (done_cnt == dc0 && n < 3000) begin step(); n++; end
        n_vec++;
        if (done_cnt == dc0) begin
            n_bad++;
            $display("FAIL done_timeout cyc=%0d got=no DONE expected=DONE within 3000 cycles", cyc);
        end
        step();
    endtask

    function automatic int total_beats(input logic [N-1:0] msk);
        int t = 0;
        for (int i = 0; i < N; i++) if (msk[i]) t += plan[i];
        return t;
    endfunction

    initial begin
        int pe_cnt[N];
        int last_wr;
        int dc0;
        logic [N-1:0] rm;

        clear_drv();
        repeat (2) step();
        chk("rst_is_idle", 32'(IS_IDLE), 32'd1);
        chk("rst_wr_cnt", 32'(WR_CNT), 32'd0);
        chk("rst_oram_vld", 32'(ORAM_VLD), 32'd0);
        rst_n = 1'b1;
        step();

        // Single PE, three beats
        do_reset();
        vld_pct = 100; rdy_pct = 100; junk = 0; stale = 0; rnd_dat = 0;
        for (int i = 0; i < N; i++) plan[i] = 3;
        start_pass(16'h0001);
        wait_done();
        chk("single_nwr", 32'(wr_add.size()), 32'd3);
        for (int k = 0; k < 3 && k < wr_add.size(); k++) begin
            chk("single_add", 32'(wr_add[k]), 32'h010 + 32'(k));
            chk("single_dat", 32'(wr_dat[k]), 32'hA1 + 32'(k));
        end
        chk("single_cnt", 32'(WR_CNT), 32'd3);
        if (wr_cyc.size() == 3) chk("single_done_lat", 32'(done_cyc), 32'(wr_cyc[2] + 1));

        // Round-robin over all PEs with a 5-cycle write stall mid-pass
        do_reset();
        for (int i = 0; i < N; i++) plan[i] = 2;
        start_pass(16'hFFFF);
        repeat (5) step();
        stall_left = 5;
        wait_done();
        chk("rr_nwr", 32'(wr_add.size()), 32'd32);
        for (int k = 0; k < 32 && k < wr_add.size(); k++) begin
            chk("rr_pe", 32'(wr_add[k][11:8]), 32'(k % 16));
            chk("rr_local", 32'(wr_add[k][7:0]), 32'h10 + 32'(k / 16));
        end
        chk("rr_cnt", 32'(WR_CNT), 32'd32);

        // Mask 0x00F0 with junk valids, stale valids after last, ignored START
        vld_pct = 60; rdy_pct = 70; junk = 1; stale = 1;
        for (int i = 0; i < N; i++) plan[i] = 3;
        plan[4] = 2;
        start_pass(16'h00F0);
        repeat (3) step();
        CFG_PE_MSK = 16'hFFFF;
        START = 1'b1;
        step();
        wait_done();
        for (int i = 0; i < N; i++) pe_cnt[i] = 0;
        last_wr = 0;
        foreach (wr_add[k]) begin
            pe_cnt[wr_add[k][11:8]]++;
            last_wr = wr_cyc[k];
        end
        for (int i = 0; i < N; i++)
            chk("msk_pe_beats", 32'(pe_cnt[i]), (i >= 4 && i <= 7) ? 32'(plan[i]) : 32'd0);
        chk("msk_cnt", 32'(WR_CNT), 32'd11);
        chk("msk_done_after_wr", 32'(done_cyc > last_wr), 32'd1);

        // Empty mask
        junk = 0; stale = 0;
        start_pass(16'h0000);
        wait_done();
        chk("empty_done_lat", 32'(done_cyc - start_cyc), 32'd3);
        chk("empty_cnt", 32'(WR_CNT), 32'd0);

        // Reset while the output register holds a beat
        vld_pct = 100; rdy_pct = 40; rnd_dat = 1;
        start_pass(16'hFFFF);
        for (int n = 0; n < 50 && !ORAM_VLD; n++) step();
        chk("mid_vld_before", 32'(ORAM_VLD), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(ORAM_VLD), 32'd0);
        chk("mid_rst_idle", 32'(IS_IDLE), 32'd1);
        chk("mid_rst_cnt", 32'(WR_CNT), 32'd0);
        clear_drv();
        dc0 = done_cnt;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("mid_no_done", 32'(done_cnt), 32'(dc0));
        for (int i = 0; i < N; i++) plan[i] = 1 + (i % 3);
        start_pass(16'h0F0F);
        wait_done();
        chk("mid_clean_cnt", 32'(WR_CNT), 32'(total_beats(16'h0F0F)));

        // Random passes
        for (int p = 0; p < 8; p++) begin
            rm = 16'($urandom);
            if (p == 0) rm = 16'hFFFF;
            for (int i = 0; i < N; i++) plan[i] = $urandom_range(1, 4);
            vld_pct = $urandom_range(40, 100);
            rdy_pct = $urandom_range(30, 100);
            junk = $urandom_range(0, 1) == 1;
            stale = $urandom_range(0, 1) == 1;
            start_pass(rm);
            wait_done();
            chk("rand_cnt", 32'(WR_CNT), 32'(total_beats(rm)));
            chk("rand_nwr", 32'(wr_add.size()), 32'(total_beats(rm)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
